// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: a 3-state FSM grants one requester per access
// and returns a one-cycle ack with load data.
module dm_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [1:0]        p0_whb,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [1:0]        p1_whb,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic [31:0]       rdata,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic [1:0]        dm_whb,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          whb_q, whb_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                win_sel;

  // Ties go to port 0 in fixed mode, otherwise to the port not served last.
  always_comb begin
    win_sel = p1_req;
    if (p0_req && p1_req) begin
      win_sel = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    whb_d        = whb_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d      = ACCESS;
          last_grant_d = win_sel;
          win_d        = win_sel;
          we_d         = win_sel ? p1_we    : p0_we;
          addr_d       = win_sel ? p1_addr  : p0_addr;
          wdata_d      = win_sel ? p1_wdata : p0_wdata;
          whb_d        = win_sel ? p1_whb   : p0_whb;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) begin
          rdata_d = dm_dout;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      whb_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      whb_q        <= whb_d;
      rdata_q      <= rdata_d;
    end
  end

  // rst gates dm_wr combinationally so an aborted store never lands.
  always_comb begin
    dm_wr   = (state_q == ACCESS) && we_q && !rst;
    dm_addr = (state_q == ACCESS) ? addr_q  : '0;
    dm_din  = (state_q == ACCESS) ? wdata_q : '0;
    dm_whb  = (state_q == ACCESS) ? whb_q   : '0;
    p0_ack  = (state_q == RESP) && !win_q;
    p1_ack  = (state_q == RESP) &&  win_q;
    rdata   = rdata_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench: round-robin instance with a byte-lane memory model, plus a
// fixed-priority instance for the tie-break behaviour.
module tb_dm_arbiter;

  localparam logic [1:0] SW = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SB = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_p0_req, a_p0_we, a_p1_req, a_p1_we;
  logic [8:0]  a_p0_addr, a_p1_addr;
  logic [31:0] a_p0_wdata, a_p1_wdata;
  logic [1:0]  a_p0_whb, a_p1_whb;
  logic        a_p0_ack, a_p1_ack, a_dm_wr;
  logic [31:0] a_rdata, a_dm_din, a_dm_dout;
  logic [8:0]  a_dm_addr;
  logic [1:0]  a_dm_whb;

  logic        b_p0_req, b_p1_req;
  logic        b_p0_ack, b_p1_ack, b_dm_wr;
  logic [31:0] b_rdata, b_dm_din;
  logic [31:0] b_dm_dout = 32'h0;
  logic [8:0]  b_dm_addr;
  logic [1:0]  b_dm_whb;
  logic [8:0]  b_addr = 9'h0;
  logic [31:0] b_wdata = 32'h0;
  logic [1:0]  b_whb = 2'b00;
  logic        b_we = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mem [0:127];

  dm_arbiter #(.ADDR_W(9), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr),
    .p0_wdata(a_p0_wdata), .p0_whb(a_p0_whb),
    .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr),
    .p1_wdata(a_p1_wdata), .p1_whb(a_p1_whb),
    .p0_ack(a_p0_ack), .p1_ack(a_p1_ack), .rdata(a_rdata),
    .dm_wr(a_dm_wr), .dm_addr(a_dm_addr), .dm_din(a_dm_din),
    .dm_whb(a_dm_whb), .dm_dout(a_dm_dout)
  );

  dm_arbiter #(.ADDR_W(9), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_we(b_we), .p0_addr(b_addr),
    .p0_wdata(b_wdata), .p0_whb(b_whb),
    .p1_req(b_p1_req), .p1_we(b_we), .p1_addr(b_addr),
    .p1_wdata(b_wdata), .p1_whb(b_whb),
    .p0_ack(b_p0_ack), .p1_ack(b_p1_ack), .rdata(b_rdata),
    .dm_wr(b_dm_wr), .dm_addr(b_dm_addr), .dm_din(b_dm_din),
    .dm_whb(b_dm_whb), .dm_dout(b_dm_dout)
  );

  // Little-endian word memory with SW/SH/SB lane writes.
  assign a_dm_dout = mem[a_dm_addr[8:2]];
  always @(posedge clk) begin
    if (a_dm_wr) begin
      case (a_dm_whb)
        SW: mem[a_dm_addr[8:2]] <= a_dm_din;
        SH: mem[a_dm_addr[8:2]][16*a_dm_addr[1] +: 16] <= a_dm_din[15:0];
        SB: mem[a_dm_addr[8:2]][8*a_dm_addr[1:0] +: 8] <= a_dm_din[7:0];
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [1:0] whb);
    a_p0_req = req; a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wdata; a_p0_whb = whb;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [1:0] whb);
    a_p1_req = req; a_p1_we = we; a_p1_addr = addr; a_p1_wdata = wdata; a_p1_whb = whb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_p0(1'b0, 1'b0, 9'h0, 32'h0, SW);
    set_p1(1'b0, 1'b0, 9'h0, 32'h0, SW);
    b_p0_req = 1'b0; b_p1_req = 1'b0;
    nxt(); nxt();
    check("rst_p0_ack", 32'(a_p0_ack), 32'h0);
    check("rst_p1_ack", 32'(a_p1_ack), 32'h0);
    check("rst_dm_wr", 32'(a_dm_wr), 32'h0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_dm_addr", 32'(a_dm_addr), 32'h0);
    rst = 1'b0;
    nxt();
    check("rel_acks", 32'({a_p0_ack, a_p1_ack}), 32'h0);
    check("rel_dm_wr", 32'(a_dm_wr), 32'h0);
    check("rel_dm_din", a_dm_din, 32'h0);
    check("rel_dm_whb", 32'(a_dm_whb), 32'h0);

    // preload word 8 through port 1
    set_p1(1'b1, 1'b1, 9'h020, 32'h12345678, SW);
    nxt();
    check("pre_dm_wr", 32'(a_dm_wr), 32'h1);
    nxt();
    check("pre_p1_ack", 32'(a_p1_ack), 32'h1);
    set_p1(1'b0, 1'b0, 9'h0, 32'h0, SW);
    nxt();

    // port 0 word store then load back
    set_p0(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, SW);
    nxt();
    check("st_dm_wr", 32'(a_dm_wr), 32'h1);
    check("st_dm_addr", 32'(a_dm_addr), 32'h010);
    check("st_dm_din", a_dm_din, 32'hDEADBEEF);
    check("st_dm_whb", 32'(a_dm_whb), 32'(SW));
    check("st_early_ack", 32'(a_p0_ack), 32'h0);
    nxt();
    check("st_p0_ack", 32'(a_p0_ack), 32'h1);
    check("st_p1_ack", 32'(a_p1_ack), 32'h0);
    check("st_wr_once", 32'(a_dm_wr), 32'h0);
    set_p0(1'b0, 1'b0, 9'h0, 32'h0, SW);
    nxt();
    check("st_ack_drop", 32'(a_p0_ack), 32'h0);
    check("st_mem4", mem[4], 32'hDEADBEEF);

    set_p0(1'b1, 1'b0, 9'h010, 32'h0, SW);
    nxt();
    check("ld_dm_wr", 32'(a_dm_wr), 32'h0);
    check("ld_dm_addr", 32'(a_dm_addr), 32'h010);
    nxt();
    check("ld_p0_ack", 32'(a_p0_ack), 32'h1);
    check("ld_rdata", a_rdata, 32'hDEADBEEF);
    set_p0(1'b0, 1'b0, 9'h0, 32'h0, SW);
    nxt();

    // port 1 byte store into lane 3 of word 4
    set_p1(1'b1, 1'b1, 9'h013, 32'h000000AA, SB);
    nxt();
    check("sb_dm_addr", 32'(a_dm_addr), 32'h013);
    check("sb_dm_din", a_dm_din, 32'h000000AA);
    check("sb_dm_whb", 32'(a_dm_whb), 32'(SB));
    check("sb_dm_wr", 32'(a_dm_wr), 32'h1);
    nxt();
    check("sb_p1_ack", 32'(a_p1_ack), 32'h1);
    check("sb_p0_ack", 32'(a_p0_ack), 32'h0);
    set_p1(1'b0, 1'b0, 9'h0, 32'h0, SW);
    nxt();
    check("sb_mem4", mem[4], 32'hAAADBEEF);

    // round-robin from reset, both held
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    set_p0(1'b1, 1'b0, 9'h010, 32'h0, SW);
    set_p1(1'b1, 1'b0, 9'h020, 32'h0, SW);
    for (int k = 1; k <= 12; k++) begin
      logic e0, e1;
      logic [31:0] ea;
      nxt();
      e0 = (k == 2) || (k == 8);
      e1 = (k == 5) || (k == 11);
      ea = (k == 1 || k == 7) ? 32'h010 : (k == 4 || k == 10) ? 32'h020 : 32'h0;
      check($sformatf("rr_p0_ack_k%0d", k), 32'(a_p0_ack), 32'(e0));
      check($sformatf("rr_p1_ack_k%0d", k), 32'(a_p1_ack), 32'(e1));
      check($sformatf("rr_dm_addr_k%0d", k), 32'(a_dm_addr), ea);
      if (e0) check($sformatf("rr_rdata_k%0d", k), a_rdata, 32'hAAADBEEF);
      if (e1) check($sformatf("rr_rdata_k%0d", k), a_rdata, 32'h12345678);
    end
    set_p0(1'b0, 1'b0, 9'h0, 32'h0, SW);
    set_p1(1'b0, 1'b0, 9'h0, 32'h0, SW);
    nxt();

    // reset aborts a store mid-access
    set_p0(1'b1, 1'b1, 9'h020, 32'hFFFFFFFF, SW);
    nxt();
    check("ab_dm_wr_pre", 32'(a_dm_wr), 32'h1);
    rst = 1'b1;
    #1;
    check("ab_dm_wr_rst", 32'(a_dm_wr), 32'h0);
    nxt();
    check("ab_acks", 32'({a_p0_ack, a_p1_ack}), 32'h0);
    check("ab_dm_addr", 32'(a_dm_addr), 32'h0);
    rst = 1'b0;
    set_p0(1'b0, 1'b0, 9'h0, 32'h0, SW);
    nxt();
    check("ab_acks_after", 32'({a_p0_ack, a_p1_ack}), 32'h0);
    check("ab_mem8", mem[8], 32'h12345678);

    // port 0 raised during port 1 RESP
    set_p1(1'b1, 1'b0, 9'h020, 32'h0, SW);
    nxt();
    nxt();
    check("lt_p1_ack", 32'(a_p1_ack), 32'h1);
    check("lt_p1_rdata", a_rdata, 32'h12345678);
    set_p1(1'b0, 1'b0, 9'h0, 32'h0, SW);
    set_p0(1'b1, 1'b0, 9'h010, 32'h0, SW);
    nxt();
    check("lt_idle_ack", 32'(a_p0_ack), 32'h0);
    check("lt_idle_addr", 32'(a_dm_addr), 32'h0);
    nxt();
    check("lt_acc_ack", 32'(a_p0_ack), 32'h0);
    check("lt_acc_addr", 32'(a_dm_addr), 32'h010);
    nxt();
    check("lt_p0_ack", 32'(a_p0_ack), 32'h1);
    check("lt_p0_rdata", a_rdata, 32'hAAADBEEF);
    set_p0(1'b0, 1'b0, 9'h0, 32'h0, SW);
    nxt();

    // fixed priority: port 1 waits until port 0 drops
    b_p0_req = 1'b1; b_p1_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      check($sformatf("fp_p0_ack_k%0d", k), 32'(b_p0_ack), 32'((k == 2) || (k == 5)));
      check($sformatf("fp_p1_ack_k%0d", k), 32'(b_p1_ack), 32'(k == 8));
      if (k == 5) b_p0_req = 1'b0;
    end
    b_p1_req = 1'b0;
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width shared with the data memory.
REQ-002 Parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = port 0 always wins ties.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 p0_req, p1_req  input  1 each  access request; held high with fields stable until matching ack.
REQ-006 p0_we, p1_we  input  1 each  1 = store, 0 = load.
REQ-007 p0_addr, p1_addr  input  ADDR_W each  byte address.
REQ-008 p0_wdata, p1_wdata  input  32 each  store data.
REQ-009 p0_whb, p1_whb  input  2 each  store width code (STOREwhb encoding), ignored for loads.
REQ-010 p0_ack, p1_ack  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  32  load result, valid only while an ack is high.
REQ-012 dm_wr  output  1  write enable to data memory (DMWr).
REQ-013 dm_addr  output  ADDR_W  memory address; dm_din  output  32; dm_whb  output  2.
REQ-014 dm_dout  input  32  memory read word (combinational from dm_addr).

Function
REQ-015 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req high; ACCESS->RESP always; RESP->IDLE always.
REQ-016 In IDLE, winner selection: one req high -> that port; both high, FIXED_PRIO=1 -> port 0; both high, FIXED_PRIO=0 -> port opposite last_grant.
REQ-017 On IDLE->ACCESS, winner id, we, addr, wdata, whb latched into internal registers; last_grant updated to winner.
REQ-018 In ACCESS, dm_addr/dm_din/dm_whb driven from latched registers; dm_wr = latched we AND NOT rst.
REQ-019 Outside ACCESS: dm_wr = 0, dm_addr/dm_din/dm_whb = 0.
REQ-020 At end of ACCESS, dm_dout captured into rdata register for loads; rdata unchanged for stores.
REQ-021 In RESP, ack of winner port = 1 for exactly one cycle; other ack = 0.
REQ-022 Latency: req seen high at edge N -> ACCESS cycle N+1 -> ack cycle N+2; max throughput one access per 3 cycles.
REQ-023 Requester drops req the cycle after ack; a req still high in the IDLE following RESP is a new request.
REQ-024 Losing port's req stays pending, no ack; granted next IDLE under round-robin (no starvation beyond one access).
REQ-025 Requests arriving during ACCESS/RESP are not sampled until IDLE.
REQ-026 Address, whb and alignment passed through unchanged; no range or alignment checking.
REQ-027 Only one store reaches memory per grant; dm_wr never high for two consecutive cycles.

Reset
REQ-028 On rst at posedge: state = IDLE, last_grant = 1 (port 0 wins first tie), latched registers = 0, rdata = 0, both acks = 0.
REQ-029 rst during ACCESS suppresses dm_wr in that same cycle; aborted access is never acked.
REQ-030 All outputs 0 in the cycle after reset release until a request is granted.

Verification
REQ-031 Port 0 store addr 0x010, wdata 0xDEADBEEF, whb=SW -> dm_wr=1 one cycle later, p0_ack two cycles after req; subsequent port 0 load 0x010 -> rdata 0xDEADBEEF with ack.
REQ-032 Both req high from reset, FIXED_PRIO=0, held continuously -> grants alternate 0,1,0,1; acks on cycles 2,5,8,11 after first sampling.
REQ-033 FIXED_PRIO=1, both req high -> port 0 acked; port 1 acked only after port 0 drops req.
REQ-034 Port 1 byte store whb=SB, addr 0x013, wdata 0x000000AA -> dm_addr 0x013, dm_din 0x000000AA, dm_whb=SB in ACCESS.
REQ-035 rst asserted during ACCESS of a store -> dm_wr=0 that cycle, no ack, memory word unchanged, state IDLE next cycle.
REQ-036 Port 0 req raised during port 1 RESP -> not granted until IDLE; p0_ack exactly 2 cycles after that IDLE.
